// File: rtl/coin_acceptor.sv
// coin_acceptor
// Synchronizes and debounces the optical coin-chute sensor, measures how long
// each coin blocks the beam, classifies it by width and queues accepted coins
// in a 4-deep FIFO presented over a valid/ready handshake.
//
// Optional feature macro: COIN_ACCEPTOR_REJECT_EN
//   defined   : reject_gate drives the diverter for REJECT_CYCLES per reject
//   undefined : reject counter removed, reject_gate tied 0, rejects dropped
//
// Handshake: coin_valid is high whenever the FIFO holds a coin and coin_code
// shows the head entry; the head is consumed on any clock edge where
// coin_valid and coin_ready are both high, and coin_code is held otherwise.
//
// dbg_state exposes the FSM state encoding (ARM=0, IDLE=1, MEASURE=2,
// CLASSIFY=3, JAM=4).
module coin_acceptor #(
  parameter int DEBOUNCE  = 4,
  parameter int DIME_W    = 30,
  parameter int NICKEL_W  = 40,
  parameter int QUARTER_W = 50,
  parameter int HALF_W    = 65,
  parameter int DOLLAR_W  = 80,
  parameter int TOL       = 3
`ifdef COIN_ACCEPTOR_REJECT_EN
  , parameter int REJECT_CYCLES = 20
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_sense,
  input  logic       accept_en,
  input  logic       coin_ready,
  output logic       coin_valid,
  output logic [2:0] coin_code,
  output logic [2:0] coin_pending,
  output logic       reject_gate,
  output logic       jam,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    ARM      = 3'd0,
    IDLE     = 3'd1,
    MEASURE  = 3'd2,
    CLASSIFY = 3'd3,
    JAM      = 3'd4
  } state_t;

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE - 1);

  state_t     state;
  logic       sync1, sync2;
  logic       filt;
  logic [7:0] db_cnt;
  logic [7:0] width;

  logic [2:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;

  logic [2:0] cls_code;
  logic       pop, push, has_space, accept;

  // Width window test: |w - nom| <= TOL.
  function automatic logic in_win(input logic [7:0] w, input int nom);
    int wi;
    wi = int'({24'd0, w});
    return (wi >= nom - TOL) && (wi <= nom + TOL);
  endfunction

  // Two-flop synchronizer for the asynchronous sensor.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= coin_sense;
      sync2 <= sync1;
    end
  end

  // Debounce: adopt the synchronized level after DEBOUNCE consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt   <= 1'b1;
      db_cnt <= 8'd0;
    end else if (sync2 == filt) begin
      db_cnt <= 8'd0;
    end else if (db_cnt == DB_LAST) begin
      filt   <= sync2;
      db_cnt <= 8'd0;
    end else begin
      db_cnt <= db_cnt + 8'd1;
    end
  end

  // Classification of the measured width and the accept decision.
  always_comb begin
    cls_code = 3'd0;
    if (in_win(width, NICKEL_W))       cls_code = 3'd1;
    else if (in_win(width, DIME_W))    cls_code = 3'd2;
    else if (in_win(width, QUARTER_W)) cls_code = 3'd3;
    else if (in_win(width, HALF_W))    cls_code = 3'd4;
    else if (in_win(width, DOLLAR_W))  cls_code = 3'd5;
    pop       = coin_valid & coin_ready;
    has_space = (count != 3'd4) || pop;
    accept    = (cls_code != 3'd0) && accept_en && has_space;
    push      = (state == CLASSIFY) && accept;
  end

  // Coin FSM with width counter; width counts every MEASURE cycle including
  // the one that sees the fall, so a clean pulse measures its raw high time.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARM;
      width <= 8'd0;
      jam   <= 1'b0;
    end else begin
      case (state)
        ARM: begin
          if (!filt) state <= IDLE;
        end
        IDLE: begin
          if (filt) begin
            width <= 8'd0;
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (width != 8'hFF) width <= width + 8'd1;
          if (!filt) begin
            state <= CLASSIFY;
          end else if (width == 8'd254) begin
            state <= JAM;
            jam   <= 1'b1;
          end
        end
        CLASSIFY: begin
          state <= IDLE;
        end
        JAM: begin
          if (!filt) begin
            state <= IDLE;
            jam   <= 1'b0;
          end
        end
        default: begin
          state <= ARM;
          jam   <= 1'b0;
        end
      endcase
    end
  end

  // Circular 4-entry FIFO; push and pop may coincide at any occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
      for (int i = 0; i < 4; i++) mem[i] <= 3'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= cls_code;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  assign coin_valid   = (count != 3'd0);
  assign coin_code    = coin_valid ? mem[rd_ptr] : 3'd0;
  assign coin_pending = count;
  assign dbg_state    = state;

`ifdef COIN_ACCEPTOR_REJECT_EN
  logic       rej_req;
  logic [7:0] rej_cnt;

  assign rej_req = ((state == CLASSIFY) && !accept) || ((state == JAM) && !filt);

  // Reject pulse timer; a new reject reloads it.
  always_ff @(posedge clk) begin
    if (rst)                  rej_cnt <= 8'd0;
    else if (rej_req)         rej_cnt <= 8'(REJECT_CYCLES);
    else if (rej_cnt != 8'd0) rej_cnt <= rej_cnt - 8'd1;
  end

  assign reject_gate = (rej_cnt != 8'd0);
`else
  assign reject_gate = 1'b0;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed testbench for coin_acceptor: clean coins, glitch rejection,
// unmatched widths, FIFO fill/drain, simultaneous push/pop at full,
// accept_en low, jam and reset with the beam blocked.
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_sense;
  logic       accept_en;
  logic       coin_ready;
  logic       coin_valid;
  logic [2:0] coin_code;
  logic [2:0] coin_pending;
  logic       reject_gate;
  logic       jam;
  logic [2:0] dbg_state;

  int checks   = 0;
  int failures = 0;

`ifdef COIN_ACCEPTOR_REJECT_EN
  localparam logic REJ_EN = 1'b1;
`else
  localparam logic REJ_EN = 1'b0;
`endif

  coin_acceptor dut (
    .clk          (clk),
    .rst          (rst),
    .coin_sense   (coin_sense),
    .accept_en    (accept_en),
    .coin_ready   (coin_ready),
    .coin_valid   (coin_valid),
    .coin_code    (coin_code),
    .coin_pending (coin_pending),
    .reject_gate  (reject_gate),
    .jam          (jam),
    .dbg_state    (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic wait_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the beam blocked for w sampled edges; call 1 unit after an edge.
  task automatic pulse(input int w);
    coin_sense = 1'b1;
    wait_n(w);
    coin_sense = 1'b0;
  endtask

  // Check the head code, pop it, then check the remaining occupancy.
  task automatic pop_check(input string tag, input logic [2:0] exp_code, input logic [2:0] exp_pend);
    @(negedge clk);
    chk({tag, "_code"}, 32'(coin_code), 32'(exp_code));
    coin_ready = 1'b1;
    @(posedge clk);
    #1;
    coin_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_pend"}, 32'(coin_pending), 32'(exp_pend));
    wait_n(1);
  endtask

  initial begin
    int hi;

    // Reset
    rst        = 1'b1;
    coin_sense = 1'b0;
    accept_en  = 1'b1;
    coin_ready = 1'b0;
    wait_n(4);
    @(negedge clk);
    chk("rst_valid",   32'(coin_valid),   32'd0);
    chk("rst_code",    32'(coin_code),    32'd0);
    chk("rst_pending", 32'(coin_pending), 32'd0);
    chk("rst_reject",  32'(reject_gate),  32'd0);
    chk("rst_jam",     32'(jam),          32'd0);
    chk("rst_state",   32'(dbg_state),    32'd0);
    wait_n(1);
    rst = 1'b0;
    wait_n(12);
    @(negedge clk);
    chk("armed_idle", 32'(dbg_state), 32'd1);
    wait_n(1);

    // Clean 50-cycle quarter: valid exactly DEBOUNCE+4 edges after the fall
    pulse(50);
    wait_n(7);
    @(negedge clk);
    chk("q_valid_early", 32'(coin_valid), 32'd0);
    wait_n(1);
    @(negedge clk);
    chk("q_valid",   32'(coin_valid),   32'd1);
    chk("q_code",    32'(coin_code),    32'd3);
    chk("q_pending", 32'(coin_pending), 32'd1);
    chk("q_reject",  32'(reject_gate),  32'd0);
    wait_n(1);
    pop_check("q_pop", 3'd3, 3'd0);
    @(negedge clk);
    chk("q_empty_code", 32'(coin_code), 32'd0);
    wait_n(5);

    // 40-cycle nickel with two 2-cycle glitches
    coin_sense = 1'b1; wait_n(10);
    coin_sense = 1'b0; wait_n(2);
    coin_sense = 1'b1; wait_n(10);
    coin_sense = 1'b0; wait_n(2);
    coin_sense = 1'b1; wait_n(16);
    coin_sense = 1'b0;
    wait_n(8);
    @(negedge clk);
    chk("n_code",    32'(coin_code),    32'd1);
    chk("n_pending", 32'(coin_pending), 32'd1);
    wait_n(20);
    @(negedge clk);
    chk("n_single", 32'(coin_pending), 32'd1);
    wait_n(1);
    pop_check("n_pop", 3'd1, 3'd0);
    wait_n(5);

    // 58-cycle coin matches no window: rejected, pulse length counted
    pulse(58);
    wait_n(7);
    @(negedge clk);
    chk("u_rej_early", 32'(reject_gate), 32'd0);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (reject_gate) hi++;
    end
    chk("u_rej_len", 32'(hi), REJ_EN ? 32'd20 : 32'd0);
    chk("u_pending", 32'(coin_pending), 32'd0);
    wait_n(5);

    // accept_en low rejects a valid quarter
    accept_en = 1'b0;
    pulse(50);
    wait_n(8);
    @(negedge clk);
    chk("dis_pending", 32'(coin_pending), 32'd0);
    chk("dis_reject",  32'(reject_gate),  32'(REJ_EN));
    wait_n(1);
    accept_en = 1'b1;
    wait_n(25);

    // Five dollars with coin_ready low: four queued, fifth rejected
    for (int i = 0; i < 4; i++) begin
      pulse(80);
      wait_n(12);
    end
    @(negedge clk);
    chk("d_full_pending", 32'(coin_pending), 32'd4);
    wait_n(1);
    pulse(80);
    wait_n(8);
    @(negedge clk);
    chk("d5_pending", 32'(coin_pending), 32'd4);
    chk("d5_reject",  32'(reject_gate),  32'(REJ_EN));
    chk("d5_code",    32'(coin_code),    32'd5);
    wait_n(25);
    coin_ready = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      @(posedge clk);
      @(negedge clk);
      chk("d_drain", 32'(coin_pending), 32'(i));
    end
    coin_ready = 1'b0;
    chk("d_drain_valid", 32'(coin_valid), 32'd0);
    wait_n(5);

    // Full FIFO, dime classified on the same edge as a head pop
    for (int i = 0; i < 4; i++) begin
      pulse(50);
      wait_n(12);
    end
    pulse(30);
    wait_n(7);
    coin_ready = 1'b1;
    wait_n(1);
    coin_ready = 1'b0;
    @(negedge clk);
    chk("sp_pending", 32'(coin_pending), 32'd4);
    chk("sp_reject",  32'(reject_gate),  32'd0);
    wait_n(1);
    pop_check("sp_pop1", 3'd3, 3'd3);
    pop_check("sp_pop2", 3'd3, 3'd2);
    pop_check("sp_pop3", 3'd3, 3'd1);
    pop_check("sp_dime", 3'd2, 3'd0);
    wait_n(5);

    // Jam: beam blocked 300 cycles
    coin_sense = 1'b1;
    wait_n(261);
    @(negedge clk);
    chk("jam_early", 32'(jam), 32'd0);
    wait_n(1);
    @(negedge clk);
    chk("jam_rise", 32'(jam), 32'd1);
    wait_n(38);
    coin_sense = 1'b0;
    wait_n(6);
    @(negedge clk);
    chk("jam_hold", 32'(jam), 32'd1);
    wait_n(1);
    @(negedge clk);
    chk("jam_clear",   32'(jam),          32'd0);
    chk("jam_reject",  32'(reject_gate),  32'(REJ_EN));
    chk("jam_pending", 32'(coin_pending), 32'd0);
    wait_n(30);

    // Reset while the beam is blocked; the remaining 42 cycles look like a nickel
    coin_sense = 1'b1;
    wait_n(25);
    rst = 1'b1;
    wait_n(3);
    rst = 1'b0;
    wait_n(42);
    coin_sense = 1'b0;
    wait_n(30);
    @(negedge clk);
    chk("rb_pending", 32'(coin_pending), 32'd0);
    chk("rb_valid",   32'(coin_valid),   32'd0);
    chk("rb_jam",     32'(jam),          32'd0);
    chk("rb_reject",  32'(reject_gate),  32'd0);
    wait_n(1);

    // Recovery: half dollar after the blocked-beam reset
    pulse(65);
    wait_n(8);
    @(negedge clk);
    chk("h_code",    32'(coin_code),    32'd4);
    chk("h_pending", 32'(coin_pending), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
